skinny_sbox_scheduler: RTL and testbench

//  Byte-serial scheduler that shares one 2-share CMS SKINNY 8-bit S-box instance (4-stage pipeline,
//  no enable, no reset) across the 16 state bytes of a round. It sits between the masked state

---
 rtl/skinny_sbox_scheduler_pkg.sv | 25 ++
 rtl/skinny_sbox_scheduler_if.sv | 42 ++++
 rtl/skinny_sbox_scheduler_tagpipe.sv | 40 ++++
 rtl/skinny_sbox_scheduler.sv | 103 ++++++++++
 tb/tb_skinny_sbox_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/skinny_sbox_scheduler_pkg.sv
// Shared types and sizes for the byte-serial SKINNY S-box scheduler.
package skinny_sched_pkg;

  localparam int unsigned NBYTES_C = 16;
  localparam int unsigned LAT_C    = 4;
  localparam int unsigned W_C      = 8;
  localparam int unsigned IDX_W_C  = 4;

  typedef logic [IDX_W_C-1:0] idx_t;
  typedef logic [W_C-1:0]     share_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One in-flight S-box slot: valid marks a real byte, idx is its write-back target.
  typedef struct packed {
    logic valid;
    idx_t idx;
  } tag_t;

endpackage

// File: rtl/skinny_sbox_scheduler_if.sv
// Bundle between scheduler, masked state file and shared S-box.
// The stall signal exists only when SKINNY_SCHED_STALL_EN is defined.
interface skinny_sched_if;
  import skinny_sched_pkg::*;

  logic   start;
  logic   busy;
  logic   done;
  idx_t   rd_idx;
  share_t rd_sh0;
  share_t rd_sh1;
  share_t sb_in0;
  share_t sb_in1;
  share_t sb_out0;
  share_t sb_out1;
  logic   wr_en;
  idx_t   wr_idx;
  share_t wr_sh0;
  share_t wr_sh1;
`ifdef SKINNY_SCHED_STALL_EN
  logic   stall;
`endif

  // Scheduler side.
  modport master (
`ifdef SKINNY_SCHED_STALL_EN
    input  stall,
`endif
    input  start, rd_sh0, rd_sh1, sb_out0, sb_out1,
    output busy, done, rd_idx, sb_in0, sb_in1, wr_en, wr_idx, wr_sh0, wr_sh1
  );

  // State file / S-box side.
  modport slave (
`ifdef SKINNY_SCHED_STALL_EN
    output stall,
`endif
    output start, rd_sh0, rd_sh1, sb_out0, sb_out1,
    input  busy, done, rd_idx, sb_in0, sb_in1, wr_en, wr_idx, wr_sh0, wr_sh1
  );

endinterface

// File: rtl/skinny_sbox_scheduler_tagpipe.sv
// LAT-deep {valid, idx} shift register that tracks bytes inside the S-box pipeline.
module skinny_sched_tagpipe
  import skinny_sched_pkg::*;
#(
  parameter int unsigned LAT = LAT_C
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic upstream_valid_c
);

  tag_t pipe [LAT];

  // Shifts every cycle in lockstep with the un-enabled S-box pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tag_out = pipe[LAT-1];

  // Any real byte still ahead of the tail entry.
  always_comb begin
    upstream_valid_c = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      upstream_valid_c = upstream_valid_c | pipe[i].valid;
    end
  end

endmodule

// File: rtl/skinny_sbox_scheduler.sv
// Issues the 16 state bytes of a round to one shared masked S-box and writes results back by tag.
// Optional issue hold input enabled by SKINNY_SCHED_STALL_EN.
module skinny_sbox_scheduler
  import skinny_sched_pkg::*;
#(
  parameter int unsigned NBYTES = NBYTES_C,
  parameter int unsigned LAT    = LAT_C
) (
  input  logic clk,
  input  logic rst_n,
  skinny_sched_if.master bus
);

  localparam idx_t LAST_IDX = idx_t'(NBYTES - 1);

  state_t state;
  idx_t   cnt;
  logic   busy_q;
  logic   done_q;
  logic   stall_c;
  logic   issue_c;
  logic   upstream_valid_c;
  tag_t   tag_in_c;
  tag_t   tag_out;

`ifdef SKINNY_SCHED_STALL_EN
  assign stall_c = bus.stall;
`else
  assign stall_c = 1'b0;
`endif

  assign issue_c = (state == ISSUE) && !stall_c;

  // Round sequencing, issue counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= ISSUE;
            busy_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_c) begin
            if (cnt == LAST_IDX) begin
              state <= DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + idx_t'(1);
            end
          end
        end
        DRAIN: begin
          if (!upstream_valid_c) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign tag_in_c = '{valid: issue_c, idx: cnt};

  skinny_sched_tagpipe #(
    .LAT (LAT)
  ) u_tagpipe (
    .clk              (clk),
    .rst_n            (rst_n),
    .tag_in           (tag_in_c),
    .tag_out          (tag_out),
    .upstream_valid_c (upstream_valid_c)
  );

  // Shares are gated independently; idle cycles present hard zeros so no stale share lingers.
  assign bus.rd_idx = cnt;
  assign bus.sb_in0 = issue_c ? bus.rd_sh0 : '0;
  assign bus.sb_in1 = issue_c ? bus.rd_sh1 : '0;

  assign bus.wr_en  = tag_out.valid;
  assign bus.wr_idx = tag_out.idx;
  assign bus.wr_sh0 = bus.sb_out0;
  assign bus.wr_sh1 = bus.sb_out1;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_skinny_sbox_scheduler.sv
// Self-checking bench: event-level reference model of the round schedule plus a masked S-box model.
// Build with SKINNY_SCHED_STALL_EN defined to exercise the stall input.
`timescale 1ns/1ps
module tb_skinny_sbox_scheduler;
  import skinny_sched_pkg::*;

  localparam int LAT = int'(LAT_C);
  localparam int NB  = int'(NBYTES_C);

  localparam logic [7:0] S8 [256] = '{
    8'h65,8'h4c,8'h6a,8'h42,8'h4b,8'h63,8'h43,8'h6b,8'h55,8'h75,8'h5a,8'h7a,8'h53,8'h73,8'h5b,8'h7b,
    8'h35,8'h8c,8'h3a,8'h81,8'h89,8'h33,8'h80,8'h3b,8'h95,8'h25,8'h98,8'h2a,8'h90,8'h23,8'h99,8'h2b,
    8'he5,8'hcc,8'he8,8'hc1,8'hc9,8'he0,8'hc0,8'he9,8'hd5,8'hf5,8'hd8,8'hf8,8'hd0,8'hf0,8'hd9,8'hf9,
    8'ha5,8'h1c,8'ha8,8'h12,8'h1b,8'ha0,8'h13,8'ha9,8'h05,8'hb5,8'h0a,8'hb8,8'h03,8'hb0,8'h0b,8'hb9,
    8'h32,8'h88,8'h3c,8'h85,8'h8d,8'h34,8'h84,8'h3d,8'h91,8'h22,8'h9c,8'h2c,8'h94,8'h24,8'h9d,8'h2d,
    8'h62,8'h4a,8'h6c,8'h45,8'h4d,8'h64,8'h44,8'h6d,8'h52,8'h72,8'h5c,8'h7c,8'h54,8'h74,8'h5d,8'h7d,
    8'ha1,8'h1a,8'hac,8'h15,8'h1d,8'ha4,8'h14,8'had,8'h02,8'hb1,8'h0c,8'hbc,8'h04,8'hb4,8'h0d,8'hbd,
    8'he1,8'hc8,8'hec,8'hc5,8'hcd,8'he4,8'hc4,8'hed,8'hd1,8'hf1,8'hdc,8'hfc,8'hd4,8'hf4,8'hdd,8'hfd,
    8'h36,8'h8e,8'h38,8'h82,8'h8b,8'h30,8'h83,8'h39,8'h96,8'h26,8'h9a,8'h28,8'h93,8'h20,8'h9b,8'h29,
    8'h66,8'h4e,8'h68,8'h41,8'h49,8'h60,8'h40,8'h69,8'h56,8'h76,8'h58,8'h78,8'h50,8'h70,8'h59,8'h79,
    8'ha6,8'h1e,8'haa,8'h11,8'h19,8'ha3,8'h10,8'hab,8'h06,8'hb6,8'h08,8'hba,8'h00,8'hb3,8'h09,8'hbb,
    8'he6,8'hce,8'hea,8'hc2,8'hcb,8'he3,8'hc3,8'heb,8'hd6,8'hf6,8'hda,8'hfa,8'hd3,8'hf3,8'hdb,8'hfb,
    8'h31,8'h8a,8'h3e,8'h86,8'h8f,8'h37,8'h87,8'h3f,8'h92,8'h21,8'h9e,8'h2e,8'h97,8'h27,8'h9f,8'h2f,
    8'h61,8'h48,8'h6e,8'h46,8'h4f,8'h67,8'h47,8'h6f,8'h51,8'h71,8'h5e,8'h7e,8'h57,8'h77,8'h5f,8'h7f,
    8'ha2,8'h18,8'hae,8'h16,8'h1f,8'ha7,8'h17,8'haf,8'h01,8'hb2,8'h0e,8'hbe,8'h07,8'hb7,8'h0f,8'hbf,
    8'he2,8'hca,8'hef,8'hc7,8'hcf,8'he7,8'hc6,8'hee,8'hd2,8'hf2,8'hdf,8'hff,8'hd7,8'hf7,8'hde,8'hfe
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t [256];
    t = S8;
    return t[x];
  endfunction

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic stall = 1'b0;
  logic stall_eff;
  logic [7:0] junk0 = 8'h00;
  logic [7:0] junk1 = 8'h00;
  logic [7:0] st0 [16];
  logic [7:0] st1 [16];
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  skinny_sched_if ifc ();

  skinny_sbox_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

`ifdef SKINNY_SCHED_STALL_EN
  assign ifc.stall = stall;
  assign stall_eff = stall;
`else
  assign stall_eff = 1'b0;
`endif

  // ---------------- reference model of the round schedule ----------------
  typedef struct {
    int         due;
    int         idx;
    logic [7:0] val;
  } exp_t;

  bit   m_active   = 1'b0;
  bit   m_issuing  = 1'b0;
  int   m_idx      = 0;
  int   m_done_cyc = -1;
  exp_t m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_issuing = 1'b0; m_idx = 0; m_done_cyc = -1;
      m_q.delete();
    end else if (m_active && cyc == m_done_cyc) begin
      m_active = 1'b0;
    end else if (m_issuing) begin
      if (!stall_eff) begin
        m_q.push_back('{due: cyc + LAT, idx: m_idx, val: sbox(st0[m_idx] ^ st1[m_idx])});
        if (m_idx == NB - 1) begin
          m_issuing = 1'b0; m_idx = 0; m_done_cyc = cyc + LAT + 1;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end else if (!m_active && ifc.start) begin
      m_active = 1'b1; m_issuing = 1'b1; m_idx = 0; m_done_cyc = -1;
    end
  end

  // State register file: real data when a byte is due, random garbage otherwise.
  always_comb begin
    if (m_issuing && !stall_eff) begin
      ifc.rd_sh0 = st0[ifc.rd_idx];
      ifc.rd_sh1 = st1[ifc.rd_idx];
    end else begin
      ifc.rd_sh0 = junk0;
      ifc.rd_sh1 = junk1;
    end
  end

  // Masked S-box model: 4-stage, free running, fresh output mask every cycle.
  logic [7:0] x_lat = 8'h00;
  logic [7:0] p0 [LAT];
  logic [7:0] p1 [LAT];
  always @(negedge clk) x_lat = ifc.sb_in0 ^ ifc.sb_in1;
  always @(posedge clk) begin
    logic [7:0] m;
    m = 8'($urandom);
    p0[0] <= sbox(x_lat) ^ m;
    p1[0] <= m;
    for (int i = 1; i < LAT; i++) begin
      p0[i] <= p0[i-1];
      p1[i] <= p1[i-1];
    end
  end
  assign ifc.sb_out0 = p0[LAT-1];
  assign ifc.sb_out1 = p1[LAT-1];

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int wr_cnt, done_cnt, busy_cnt, first_wr, last_wr, done_cyc, busy_rise;
  int wr_cyc_of [16];
  logic [7:0] val_of [16];
  logic busy_prev = 1'b0;

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
    first_wr = -1; last_wr = -1; done_cyc = -1; busy_rise = -1;
  endtask

  always @(negedge clk) begin
    logic [7:0] got;
    if (m_issuing) chk("rd_idx", 32'(ifc.rd_idx), 32'(m_idx));
    else if (!m_active) chk("rd_idx_idle", 32'(ifc.rd_idx), 32'd0);
    if (m_issuing && !stall_eff) begin
      chk("sb_in0", 32'(ifc.sb_in0), 32'(st0[m_idx]));
      chk("sb_in1", 32'(ifc.sb_in1), 32'(st1[m_idx]));
    end else begin
      chk("sb_in0_zero", 32'(ifc.sb_in0), 32'd0);
      chk("sb_in1_zero", 32'(ifc.sb_in1), 32'd0);
    end
    if (m_q.size() > 0 && m_q[0].due == cyc) begin
      chk("wr_en", 32'(ifc.wr_en), 32'd1);
      chk("wr_idx", 32'(ifc.wr_idx), 32'(m_q[0].idx));
      got = ifc.wr_sh0 ^ ifc.wr_sh1;
      chk("wr_val", 32'(got), 32'(m_q[0].val));
      void'(m_q.pop_front());
    end else begin
      chk("wr_en_quiet", 32'(ifc.wr_en), 32'd0);
    end
    chk("busy", 32'(ifc.busy), 32'(m_active));
    chk("done", 32'(ifc.done), 32'(m_active && cyc == m_done_cyc));
    if (ifc.wr_en === 1'b1) begin
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
      wr_cyc_of[ifc.wr_idx] = cyc;
      val_of[ifc.wr_idx] = ifc.wr_sh0 ^ ifc.wr_sh1;
    end
    if (ifc.done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (ifc.busy === 1'b1) begin
      busy_cnt++;
      if (!busy_prev) busy_rise = cyc;
    end
    busy_prev = ifc.busy;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    junk0 = 8'($urandom);
    junk1 = 8'($urandom);
  endtask

  // Starts a round in the current cycle (relative cycle 0) and returns at the cycle after done.
  task automatic run_round(input int pa, input int pb, input int slo, input int shi, output int s0);
    clear_stats();
    s0 = cyc;
    ifc.start = 1'b1;
    for (int i = 1; i < 80; i++) begin
      tick();
      ifc.start = (i == pa) || (i == pb);
      stall = (i >= slo) && (i <= shi);
      if (done_cnt > 0) break;
    end
    ifc.start = 1'b0;
    stall = 1'b0;
    chk("round_done_seen", 32'(done_cnt > 0), 32'd1);
  endtask

  task automatic check_nominal(input string tag, input int s0);
    chk({tag, "_busy_rise"}, 32'(busy_rise - s0), 32'd1);
    chk({tag, "_first_wr"}, 32'(first_wr - s0), 32'd5);
    chk({tag, "_last_wr"}, 32'(last_wr - s0), 32'd20);
    chk({tag, "_done_cyc"}, 32'(done_cyc - s0), 32'd21);
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd16);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int s0;
    ifc.start = 1'b0;
    for (int k = 0; k < 16; k++) begin st0[k] = 8'h00; st1[k] = 8'h00; end
    clear_stats();
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_done", 32'(ifc.done), 32'd0);
    chk("rst_wr_en", 32'(ifc.wr_en), 32'd0);
    chk("rst_rd_idx", 32'(ifc.rd_idx), 32'd0);
    chk("rst_sb_in", 32'({ifc.sb_in0, ifc.sb_in1}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Known-answer round: unmasked byte k, so results are S8(k).
    for (int k = 0; k < 16; k++) begin st0[k] = 8'(k) ^ 8'hA5; st1[k] = 8'hA5; end
    run_round(-1, -1, -1, -1, s0);
    check_nominal("kat", s0);
    chk("kat_s8_0", 32'(val_of[0]), 32'h65);
    chk("kat_s8_15", 32'(val_of[15]), 32'h7b);
    chk("kat_idx15_cyc", 32'(wr_cyc_of[15] - s0), 32'd20);
    repeat (3) tick();

    // Start pulses while active are ignored.
    for (int k = 0; k < 16; k++) begin st0[k] = 8'($urandom); st1[k] = 8'($urandom); end
    run_round(3, 10, -1, -1, s0);
    check_nominal("restart", s0);
    repeat (2) tick();

    // Async reset mid-round.
    s0 = cyc;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    clear_stats();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("rst_mid_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("rst_mid_busy_cnt", 32'(busy_cnt), 32'd0);
    chk("rst_mid_done_cnt", 32'(done_cnt), 32'd0);
    run_round(-1, -1, -1, -1, s0);
    check_nominal("post_rst", s0);
    repeat (2) tick();

`ifdef SKINNY_SCHED_STALL_EN
    for (int k = 0; k < 16; k++) begin st0[k] = 8'($urandom); st1[k] = 8'($urandom); end
    run_round(-1, -1, 4, 6, s0);
    chk("stall_idx3_wr", 32'(wr_cyc_of[3] - s0), 32'd11);
    chk("stall_first_wr", 32'(first_wr - s0), 32'd5);
    chk("stall_last_wr", 32'(last_wr - s0), 32'd23);
    chk("stall_done_cyc", 32'(done_cyc - s0), 32'd24);
    chk("stall_wr_cnt", 32'(wr_cnt), 32'd16);
    repeat (2) tick();
`endif

    // Back-to-back rounds: second start in the cycle after done.
    run_round(-1, -1, -1, -1, s0);
    check_nominal("b2b_a", s0);
    for (int k = 0; k < 16; k++) begin st0[k] = 8'($urandom); st1[k] = 8'($urandom); end
    run_round(-1, -1, -1, -1, s0);
    check_nominal("b2b_b", s0);

    // Randomized rounds: random data, stray starts, stall windows, idle gaps.
    for (int r = 0; r < 20; r++) begin
      int pa, pb, slo, shi;
      repeat ($urandom_range(0, 3)) tick();
      for (int k = 0; k < 16; k++) begin st0[k] = 8'($urandom); st1[k] = 8'($urandom); end
      pa  = int'($urandom_range(1, 20));
      pb  = int'($urandom_range(1, 20));
      slo = int'($urandom_range(1, 16));
      shi = slo + int'($urandom_range(0, 5));
      run_round(pa, pb, slo, shi, s0);
      chk("rand_wr_cnt", 32'(wr_cnt), 32'd16);
      chk("rand_done_cnt", 32'(done_cnt), 32'd1);
    end
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
